tdp_bram_pipe: RTL and testbench

//   Parametrised true dual-port block RAM on one clock domain. Ports A and B are

---
 rtl/tdp_bram_pipe.sv | 199 +++++++++++++++++++
 tb/tb_tdp_bram_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdp_bram_pipe.sv
// tdp_bram_pipe: true dual-port block RAM on a single clock.
//
// Ports A and B each do a read or a byte-masked write per cycle. Each port has
// an optional output register, so read latency is 1 + OUT_REG cycles. Writes
// also produce vld so that a port returns one result per accepted access.
//
// Ports (x = a | b):
//   clk, rst_n         clock and asynchronous active-low reset
//   en_x, we_x, be_x   request, write select, byte-lane write enables
//   addr_x, din_x      word address, write data
//   dout_x, vld_x      result word and its one-cycle valid
//   coll               one-cycle pulse after a same-address write/write with
//                      overlapping lanes
//   ready              requests are accepted only while ready = 1
//
// Optional feature macro: BRAM_CLEAR_EN. When it is defined, a clear FSM
// zeroes the array after every reset and holds ready low until it is done.
// Without the macro, ready is tied high and the array powers up uninitialised.
//
// Clear FSM (BRAM_CLEAR_EN only):
//   state   | meaning
//   S_CLEAR | writing 0 to word clr_cnt_q, one word per cycle; ready = 0
//   S_READY | array cleared; normal accesses accepted; ready = 1
//
// Collision rule: when both ports write the same word in the same cycle, a
// lane enabled on both ports takes port A's data. A lane enabled on only one
// port takes that port's data. Port A's merge is therefore based on port B's
// merged word, and port A's write to the array is applied last.

module tdp_bram_pipe #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int BYTE_W   = 8,
   parameter int OUT_REG  = 1,
   parameter int RDW_MODE = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en_a,
   input  logic                       we_a,
   input  logic [DATA_W/BYTE_W-1:0]   be_a,
   input  logic [ADDR_W-1:0]          addr_a,
   input  logic [DATA_W-1:0]          din_a,
   output logic [DATA_W-1:0]          dout_a,
   output logic                       vld_a,
   input  logic                       en_b,
   input  logic                       we_b,
   input  logic [DATA_W/BYTE_W-1:0]   be_b,
   input  logic [ADDR_W-1:0]          addr_b,
   input  logic [DATA_W-1:0]          din_b,
   output logic [DATA_W-1:0]          dout_b,
   output logic                       vld_b,
   output logic                       coll,
   output logic                       ready
);

   localparam int NB    = DATA_W / BYTE_W;
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              acc_a, acc_b, wr_a, wr_b, wr_both_same;
   logic [DATA_W-1:0] wr_a_base, wr_a_word, wr_b_word;
   logic [DATA_W-1:0] dat1_a_d, dat1_a_q, dat1_b_d, dat1_b_q;
   logic              vld1_a_d, vld1_a_q, vld1_b_d, vld1_b_q;
   logic              coll_d, coll_q;

   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] new_w,
                                               input logic [NB-1:0]     be);
      logic [DATA_W-1:0] r;
      r = old_w;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) r[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
      end
      return r;
   endfunction

`ifdef BRAM_CLEAR_EN
   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t            state_d, state_q;
   logic [ADDR_W-1:0] clr_cnt_d, clr_cnt_q;
   logic              ready_d, ready_q;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == S_CLEAR) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = S_READY;
      end
      ready_d = (state_d == S_READY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_CLEAR;
         clr_cnt_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         ready_q   <= ready_d;
      end
   end

   assign ready = ready_q;
`else
   assign ready = 1'b1;
`endif

   always_comb begin
      acc_a        = en_a & ready;
      acc_b        = en_b & ready;
      wr_a         = acc_a & we_a;
      wr_b         = acc_b & we_b;
      wr_both_same = wr_a & wr_b & (addr_a == addr_b);
      wr_b_word    = merge(mem[addr_b], din_b, be_b);
      wr_a_base    = wr_both_same ? wr_b_word : mem[addr_a];
      wr_a_word    = merge(wr_a_base, din_a, be_a);
      coll_d       = wr_both_same & (|(be_a & be_b));

      // mem[] here is still the pre-write word, which is what a cross-port
      // reader and a READ_FIRST writer must see.
      vld1_a_d = acc_a;
      vld1_b_d = acc_b;
      dat1_a_d = dat1_a_q;
      dat1_b_d = dat1_b_q;
      if (acc_a) dat1_a_d = (RDW_MODE != 0 && we_a) ? wr_a_word : mem[addr_a];
      if (acc_b) dat1_b_d = (RDW_MODE != 0 && we_b)
                            ? (wr_both_same ? wr_a_word : wr_b_word)
                            : mem[addr_b];
   end

   // Array has no reset; a write accepted at an edge always completes.
   always_ff @(posedge clk) begin
`ifdef BRAM_CLEAR_EN
      if (state_q == S_CLEAR) mem[clr_cnt_q] <= '0;
`endif
      if (wr_b) mem[addr_b] <= wr_b_word;
      if (wr_a) mem[addr_a] <= wr_a_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dat1_a_q <= '0;
         dat1_b_q <= '0;
         vld1_a_q <= 1'b0;
         vld1_b_q <= 1'b0;
         coll_q   <= 1'b0;
      end else begin
         dat1_a_q <= dat1_a_d;
         dat1_b_q <= dat1_b_d;
         vld1_a_q <= vld1_a_d;
         vld1_b_q <= vld1_b_d;
         coll_q   <= coll_d;
      end
   end

   assign coll = coll_q;

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_W-1:0] dat2_a_d, dat2_a_q, dat2_b_d, dat2_b_q;
         logic              vld2_a_q, vld2_b_q;

         always_comb begin
            dat2_a_d = vld1_a_q ? dat1_a_q : dat2_a_q;
            dat2_b_d = vld1_b_q ? dat1_b_q : dat2_b_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dat2_a_q <= '0;
               dat2_b_q <= '0;
               vld2_a_q <= 1'b0;
               vld2_b_q <= 1'b0;
            end else begin
               dat2_a_q <= dat2_a_d;
               dat2_b_q <= dat2_b_d;
               vld2_a_q <= vld1_a_q;
               vld2_b_q <= vld1_b_q;
            end
         end

         assign dout_a = dat2_a_q;
         assign dout_b = dat2_b_q;
         assign vld_a  = vld2_a_q;
         assign vld_b  = vld2_b_q;
      end else begin : g_noreg
         assign dout_a = dat1_a_q;
         assign dout_b = dat1_b_q;
         assign vld_a  = vld1_a_q;
         assign vld_b  = vld1_b_q;
      end
   endgenerate

endmodule

// File: tb/tb_tdp_bram_pipe.sv
// Directed bench for tdp_bram_pipe. Two instances share all stimulus:
//   u_dut0: OUT_REG=0, RDW_MODE=1 (latency 1, write-first)
//   u_dut1: OUT_REG=1, RDW_MODE=0 (latency 2, read-first)
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_tdp_bram_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en_a, we_a, en_b, we_b;
   logic [3:0]  be_a, be_b, addr_a, addr_b;
   logic [31:0] din_a, din_b;

   logic [31:0] dout_a0, dout_b0, dout_a1, dout_b1;
   logic        vld_a0, vld_b0, vld_a1, vld_b1, coll0, coll1, ready0, ready1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   tdp_bram_pipe #(.DATA_W(32), .ADDR_W(4), .BYTE_W(8), .OUT_REG(0), .RDW_MODE(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
      .dout_a(dout_a0), .vld_a(vld_a0),
      .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
      .dout_b(dout_b0), .vld_b(vld_b0),
      .coll(coll0), .ready(ready0));

   tdp_bram_pipe #(.DATA_W(32), .ADDR_W(4), .BYTE_W(8), .OUT_REG(1), .RDW_MODE(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
      .dout_a(dout_a1), .vld_a(vld_a1),
      .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
      .dout_b(dout_b1), .vld_b(vld_b1),
      .coll(coll1), .ready(ready1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_a(input logic en, input logic we, input logic [3:0] be,
                        input logic [3:0] addr, input logic [31:0] din);
      en_a = en; we_a = we; be_a = be; addr_a = addr; din_a = din;
   endtask

   task automatic set_b(input logic en, input logic we, input logic [3:0] be,
                        input logic [3:0] addr, input logic [31:0] din);
      en_b = en; we_b = we; be_b = be; addr_b = addr; din_b = din;
   endtask

   task automatic idle();
      set_a(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
      set_b(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
   endtask

   // One write on port A, then let both pipelines drain.
   task automatic wr_a(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] be);
      set_a(1'b1, 1'b1, be, addr, d);
      tick(); idle(); tick();
   endtask

   task automatic rd_a(input logic [3:0] addr, input logic [31:0] exp, input string tag);
      set_a(1'b1, 1'b0, 4'h0, addr, 32'h0);
      tick(); idle();
      chk({tag, "_vld_a0"}, vld_a0, 1);
      chk({tag, "_dout_a0"}, dout_a0, exp);
      tick();
      chk({tag, "_vld_a1"}, vld_a1, 1);
      chk({tag, "_dout_a1"}, dout_a1, exp);
      chk({tag, "_vld_a0_end"}, vld_a0, 0);
   endtask

   task automatic rd_b(input logic [3:0] addr, input logic [31:0] exp, input string tag);
      set_b(1'b1, 1'b0, 4'h0, addr, 32'h0);
      tick(); idle();
      chk({tag, "_vld_b0"}, vld_b0, 1);
      chk({tag, "_dout_b0"}, dout_b0, exp);
      tick();
      chk({tag, "_vld_b1"}, vld_b1, 1);
      chk({tag, "_dout_b1"}, dout_b1, exp);
      chk({tag, "_vld_b0_end"}, vld_b0, 0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!(ready0 && ready1) && n < 64) begin
         tick();
         n++;
      end
      chk("ready_reached", {31'h0, ready0 & ready1}, 1);
   endtask

`ifdef BRAM_CLEAR_EN
   // Called on the falling edge where rst_n was just released.
   task automatic clear_window(input string tag);
      for (int k = 0; k < 15; k++) begin
         if (k == 3) set_a(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
         else idle();
         tick();
         chk({tag, "_ready_low"}, ready0 | ready1, 0);
         chk({tag, "_no_vld"}, vld_a0, 0);
      end
      idle();
      tick();
      chk({tag, "_ready_high"}, {31'h0, ready0 & ready1}, 1);
      chk({tag, "_no_vld1"}, vld_a1, 0);
   endtask
`endif

   function automatic logic [31:0] pat(input int i);
      return 32'hC0DE_0000 + i * 32'h0000_0101;
   endfunction

   initial begin
      int cnt_a0, cnt_b0, cnt_a1, cnt_b1;
      rst_n = 1'b0;
      idle();
      tick(); tick();

      // Reset state
      chk("rst_dout", dout_a0 | dout_b0 | dout_a1 | dout_b1, 32'h0);
      chk("rst_vld_coll", {26'h0, vld_a0, vld_b0, vld_a1, vld_b1, coll0, coll1}, 32'h0);
`ifdef BRAM_CLEAR_EN
      chk("rst_ready", {30'h0, ready0, ready1}, 32'h0);
`else
      chk("rst_ready", {30'h0, ready0, ready1}, 32'h3);
`endif
      rst_n = 1'b1;
      wait_ready();

      // 1: writes on A, reads on B
      set_a(1'b1, 1'b1, 4'hF, 4'd1, 32'hAAAA_AAAA); tick();
      chk("wr_vld_a0", vld_a0, 1);
      set_a(1'b1, 1'b1, 4'hF, 4'd2, 32'hBBBB_BBBB); tick();
      chk("wr_vld_a1", vld_a1, 1);
      set_a(1'b1, 1'b1, 4'hF, 4'd3, 32'hCCCC_CCCC); tick();
      idle(); tick(); tick();
      rd_b(4'd1, 32'hAAAA_AAAA, "t1_addr1");
      rd_b(4'd2, 32'hBBBB_BBBB, "t1_addr2");
      rd_b(4'd3, 32'hCCCC_CCCC, "t1_addr3");

      // 2: byte merge, then a write with be=0 (vld but no change)
      wr_a(4'd5, 32'h1122_3344, 4'hF);
      wr_a(4'd5, 32'hFFFF_FFFF, 4'b0101);
      set_a(1'b1, 1'b1, 4'h0, 4'd5, 32'h0000_0000); tick(); idle();
      chk("be0_vld_a0", vld_a0, 1);
      tick(); tick();
      rd_a(4'd5, 32'h11FF_33FF, "t2_merge");

      // 3: overlapping collision, then disjoint lanes (no coll)
      wr_a(4'd7, 32'h1234_5678, 4'hF);
      set_a(1'b1, 1'b1, 4'b1100, 4'd7, 32'hAAAA_AAAA);
      set_b(1'b1, 1'b1, 4'b0110, 4'd7, 32'hBBBB_BBBB);
      tick(); idle();
      chk("coll_pulse", {30'h0, coll0, coll1}, 32'h3);
      tick();
      chk("coll_one_cycle", {30'h0, coll0, coll1}, 32'h0);
      rd_a(4'd7, 32'hAAAA_BB78, "t3_coll");
      set_a(1'b1, 1'b1, 4'b0011, 4'd8, 32'h1111_1111);
      set_b(1'b1, 1'b1, 4'b1100, 4'd8, 32'h2222_2222);
      tick(); idle();
      chk("coll_disjoint", {30'h0, coll0, coll1}, 32'h0);
      tick();
      rd_b(4'd8, 32'h2222_1111, "t3_disjoint");

      // 4: read-during-write
      wr_a(4'd4, 32'h0, 4'hF);
      set_a(1'b1, 1'b1, 4'hF, 4'd4, 32'h5A5A_5A5A);
      set_b(1'b1, 1'b0, 4'h0, 4'd4, 32'h0);
      tick(); idle();
      chk("rdw_dout_a0_wf", dout_a0, 32'h5A5A_5A5A);
      chk("rdw_dout_b0", dout_b0, 32'h0);
      tick();
      chk("rdw_dout_a1_rf", dout_a1, 32'h0);
      chk("rdw_dout_b1", dout_b1, 32'h0);
      rd_b(4'd4, 32'h5A5A_5A5A, "t4_after");

      // 5: back-to-back streaming on both ports
      for (int k = 0; k < 16; k++) begin
         set_a(1'b1, 1'b1, 4'hF, 4'(k), pat(k));
         tick();
      end
      idle(); tick(); tick();
      cnt_a0 = 0; cnt_b0 = 0; cnt_a1 = 0; cnt_b1 = 0;
      for (int k = 0; k < 18; k++) begin
         if (k < 16) begin
            set_a(1'b1, 1'b0, 4'h0, 4'(k), 32'h0);
            set_b(1'b1, 1'b0, 4'h0, 4'(15 - k), 32'h0);
         end else idle();
         tick();
         cnt_a0 += int'(vld_a0); cnt_b0 += int'(vld_b0);
         cnt_a1 += int'(vld_a1); cnt_b1 += int'(vld_b1);
         if (k < 16) begin
            chk("str_dout_a0", dout_a0, pat(k));
            chk("str_dout_b0", dout_b0, pat(15 - k));
         end
         if (k >= 1 && k <= 16) begin
            chk("str_dout_a1", dout_a1, pat(k - 1));
            chk("str_dout_b1", dout_b1, pat(16 - k));
         end
      end
      chk("str_cnt_a0", cnt_a0, 16);
      chk("str_cnt_b0", cnt_b0, 16);
      chk("str_cnt_a1", cnt_a1, 16);
      chk("str_cnt_b1", cnt_b1, 16);

      // Reset mid-operation: in-flight results dropped, write completed
      set_a(1'b1, 1'b1, 4'hF, 4'd9, 32'h9999_9999);
      tick(); idle();
      rst_n = 1'b0;
      #1;
      chk("midrst_vld", {30'h0, vld_a0, vld_a1}, 32'h0);
      tick();
      rst_n = 1'b1;
`ifdef BRAM_CLEAR_EN
      clear_window("clr1");
      rd_a(4'd9, 32'h0, "midrst_wr");
`else
      wait_ready();
      rd_a(4'd9, 32'h9999_9999, "midrst_wr");
`endif

`ifdef BRAM_CLEAR_EN
      // 6: clear after reset, restart of the clear when reset mid-clear
      wr_a(4'd3, 32'hDEAD_BEEF, 4'hF);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      clear_window("clr2");
      for (int k = 0; k < 16; k++) rd_a(4'(k), 32'h0, "clr_zero");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout tests=%0d", n_tests);
      $fatal(1, "timeout");
   end

endmodule
